// File: rtl/flappy_physics.sv
// flappy_physics: per-frame game-state engine. Advances bird physics, pipe scroll,
// collision and score once per frame clock edge; all outputs are registered.
module flappy_physics #(
  parameter int unsigned WIDTH      = 40,
  parameter int unsigned HEIGHT     = 20,
  parameter int unsigned BIRD_X     = 8,
  parameter int unsigned GAP        = 6,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned FLAP_VEL   = 6,
  parameter int unsigned MAX_FALL   = 8,
  parameter int unsigned SCROLL_DIV = 2,
  parameter int unsigned DEAD_HOLD  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flap,
  output logic [1:0]  state,
  output logic [7:0]  bird_row,
  output logic [7:0]  pipe_x,
  output logic [7:0]  gap_top,
  output logic [15:0] score
);

  typedef enum logic [1:0] {StReady = 2'd0, StPlay = 2'd1, StDead = 2'd2} state_e;

  localparam int unsigned ScrollW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned DeadW   = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;

  localparam logic [7:0]         YReady     = 8'(HEIGHT * 2);
  localparam logic [7:0]         YEntry     = 8'(HEIGHT * 2 - FLAP_VEL);
  localparam logic [7:0]         YFloor     = 8'(HEIGHT * 4 - 1);
  localparam logic signed [8:0]  YLimit     = 9'(HEIGHT * 4);
  localparam logic [7:0]         PipeStart  = 8'(WIDTH - 1);
  localparam logic [7:0]         GapReady   = 8'((HEIGHT - GAP) / 2);
  localparam logic [15:0]        GapSpan    = 16'(HEIGHT - GAP - 1);
  localparam logic [8:0]         GapH       = 9'(GAP);
  localparam logic [7:0]         BirdX      = 8'(BIRD_X);
  localparam logic signed [7:0]  VelFlap    = 8'(-int'(FLAP_VEL));
  localparam logic signed [8:0]  VelGrav    = 9'(GRAVITY);
  localparam logic signed [8:0]  VelMax     = 9'(MAX_FALL);
  localparam logic [ScrollW-1:0] ScrollLast = ScrollW'(SCROLL_DIV - 1);
  localparam logic [DeadW-1:0]   DeadLast   = DeadW'(DEAD_HOLD);
  localparam logic [15:0]        LfsrSeed   = 16'hACE1;

  state_e              state_q, state_d;
  logic [7:0]          y_q, y_d;
  logic signed [7:0]   vel_q, vel_d;
  logic [7:0]          pipe_x_q, pipe_x_d;
  logic [7:0]          gap_top_q, gap_top_d;
  logic [15:0]         score_q, score_d;
  logic [ScrollW-1:0]  scroll_q, scroll_d;
  logic [DeadW-1:0]    dead_q, dead_d;
  logic                flap_q;
  logic [15:0]         lfsr_q, lfsr_d;

  logic                fe;
  logic signed [8:0]   vel_sum;
  logic signed [7:0]   vel_n;
  logic signed [8:0]   y_sum;
  logic [7:0]          row_n;
  logic                hit_floor;
  logic                hit_pipe;

  // Next-frame game state from current state and the flap rising edge.
  always_comb begin
    fe        = flap & ~flap_q;
    // Fibonacci LFSR, taps 16/14/13/11, shifting right.
    lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    state_d   = state_q;
    y_d       = y_q;
    vel_d     = vel_q;
    pipe_x_d  = pipe_x_q;
    gap_top_d = gap_top_q;
    score_d   = score_q;
    scroll_d  = scroll_q;
    dead_d    = dead_q;
    vel_sum   = 9'sd0;
    vel_n     = 8'sd0;
    y_sum     = 9'sd0;
    row_n     = 8'd0;
    hit_floor = 1'b0;
    hit_pipe  = 1'b0;

    unique case (state_q)
      StReady: begin
        y_d       = YReady;
        vel_d     = 8'sd0;
        pipe_x_d  = PipeStart;
        gap_top_d = GapReady;
        scroll_d  = '0;
        dead_d    = '0;
        if (fe) begin
          score_d = 16'd0;
          vel_d   = VelFlap;
          y_d     = YEntry;
          state_d = StPlay;
        end
      end

      StPlay: begin
        // Clamp velocity before it is applied to the position.
        vel_sum = $signed({vel_q[7], vel_q}) + VelGrav;
        if (fe) begin
          vel_n = VelFlap;
        end else if (vel_sum > VelMax) begin
          vel_n = VelMax[7:0];
        end else begin
          vel_n = vel_sum[7:0];
        end

        // 9-bit signed so the ceiling and floor cannot wrap.
        y_sum = $signed({1'b0, y_q}) + $signed({vel_n[7], vel_n});
        if (y_sum < 9'sd0) begin
          y_d   = 8'd0;
          vel_d = 8'sd0;
        end else if (y_sum >= YLimit) begin
          y_d       = YFloor;
          vel_d     = vel_n;
          hit_floor = 1'b1;
        end else begin
          y_d   = y_sum[7:0];
          vel_d = vel_n;
        end

        if (scroll_q == ScrollLast) begin
          scroll_d = '0;
          if (pipe_x_q == 8'd0) begin
            pipe_x_d  = PipeStart;
            gap_top_d = 8'd1 + 8'(lfsr_q % GapSpan);
          end else begin
            pipe_x_d = pipe_x_q - 8'd1;
            if (pipe_x_q == BirdX && score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
            end
          end
        end else begin
          scroll_d = scroll_q + ScrollW'(1);
        end

        row_n    = {2'b00, y_d[7:2]};
        hit_pipe = (pipe_x_d == BirdX) &&
                   ((row_n < gap_top_d) || ({1'b0, row_n} >= ({1'b0, gap_top_d} + GapH)));
        if (hit_floor || hit_pipe) begin
          state_d = StDead;
          dead_d  = '0;
        end
      end

      StDead: begin
        if (dead_q != DeadLast) begin
          dead_d = dead_q + DeadW'(1);
        end else if (fe) begin
          state_d   = StReady;
          y_d       = YReady;
          vel_d     = 8'sd0;
          pipe_x_d  = PipeStart;
          gap_top_d = GapReady;
          scroll_d  = '0;
          dead_d    = '0;
        end
      end

      default: state_d = StReady;
    endcase
  end

  // Frame register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StReady;
      y_q       <= YReady;
      vel_q     <= 8'sd0;
      pipe_x_q  <= PipeStart;
      gap_top_q <= GapReady;
      score_q   <= 16'd0;
      scroll_q  <= '0;
      dead_q    <= '0;
      flap_q    <= 1'b0;
      lfsr_q    <= LfsrSeed;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      pipe_x_q  <= pipe_x_d;
      gap_top_q <= gap_top_d;
      score_q   <= score_d;
      scroll_q  <= scroll_d;
      dead_q    <= dead_d;
      flap_q    <= flap;
      lfsr_q    <= lfsr_d;
    end
  end

  assign state    = state_q;
  assign bird_row = {2'b00, y_q[7:2]};
  assign pipe_x   = pipe_x_q;
  assign gap_top  = gap_top_q;
  assign score    = score_q;

endmodule

// File: tb/tb_flappy_physics.sv
// Directed bench for flappy_physics with hand-computed trajectories.
module tb_flappy_physics;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flap = 1'b0;
  logic [1:0]  state;
  logic [7:0]  bird_row;
  logic [7:0]  pipe_x;
  logic [7:0]  gap_top;
  logic [15:0] score;

  int checks = 0;
  int fails  = 0;

  // y over one 13-frame flap cycle, starting on the flap frame.
  int cyc_y[13] = '{34, 29, 25, 22, 20, 19, 19, 20, 22, 25, 29, 34, 40};
  // y after the entry flap with no further flaps.
  int fall_y[17] = '{29, 25, 22, 20, 19, 19, 20, 22, 25, 29, 34, 40, 47, 55, 63, 71, 79};
  logic [15:0] exp_gap_wrap;

  always #5 clk = ~clk;

  flappy_physics dut (
    .clk      (clk),
    .rst      (rst),
    .flap     (flap),
    .state    (state),
    .bird_row (bird_row),
    .pipe_x   (pipe_x),
    .gap_top  (gap_top),
    .score    (score)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, got no finish, required finish");
    $fatal(1);
  end

  task automatic frame(input logic f);
    flap = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame(1'b0);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    frame(1'b0);
    frame(1'b0);
    rst = 1'b0;
    checks++; if (state !== 2'd0) begin fails++;
      $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (bird_row !== 8'd10) begin fails++;
      $display("FAIL reset_row: got %0d want 10", bird_row); end
    checks++; if (pipe_x !== 8'd39) begin fails++;
      $display("FAIL reset_pipe: got %0d want 39", pipe_x); end
    checks++; if (gap_top !== 8'd7) begin fails++;
      $display("FAIL reset_gap: got %0d want 7", gap_top); end
    checks++; if (score !== 16'd0) begin fails++;
      $display("FAIL reset_score: got %0d want 0", score); end
  endtask

  task automatic test_ideal_fall();
    frame(1'b1);
    checks++; if (state !== 2'd1) begin fails++;
      $display("FAIL fall_entry_state: got %0d want 1", state); end
    checks++; if (bird_row !== 8'd8) begin fails++;
      $display("FAIL fall_entry_row: got %0d want 8", bird_row); end
    for (int k = 1; k <= 17; k++) begin
      frame(1'b0);
      checks++; if (bird_row !== 8'(fall_y[k-1] / 4) || state !== 2'd1) begin fails++;
        $display("FAIL fall_row k=%0d: got row %0d state %0d want row %0d state 1",
                 k, bird_row, state, fall_y[k-1] / 4); end
      checks++; if (pipe_x !== 8'(39 - k / 2)) begin fails++;
        $display("FAIL fall_pipe k=%0d: got %0d want %0d", k, pipe_x, 39 - k / 2); end
    end
    frame(1'b0);
    checks++; if (state !== 2'd2) begin fails++;
      $display("FAIL fall_dead_state: got %0d want 2", state); end
    checks++; if (bird_row !== 8'd19) begin fails++;
      $display("FAIL fall_dead_row: got %0d want 19", bird_row); end
    checks++; if (score !== 16'd0) begin fails++;
      $display("FAIL fall_dead_score: got %0d want 0", score); end
    checks++; if (pipe_x !== 8'd30) begin fails++;
      $display("FAIL fall_dead_pipe: got %0d want 30", pipe_x); end
  endtask

  task automatic test_reset_from_dead();
    frame(1'b0);
    rst = 1'b1;
    frame(1'b0);
    rst = 1'b0;
    checks++; if (state !== 2'd0 || bird_row !== 8'd10 || pipe_x !== 8'd39 ||
                  gap_top !== 8'd7 || score !== 16'd0) begin fails++;
      $display("FAIL reset_dead: got %0d/%0d/%0d/%0d/%0d want 0/10/39/7/0",
               state, bird_row, pipe_x, gap_top, score); end
  endtask

  task automatic test_pipe_pass();
    do_reset();
    frame(1'b1);
    for (int k = 1; k <= 80; k++) begin
      frame(k % 13 == 0);
      checks++; if (state !== 2'd1 || bird_row !== 8'(cyc_y[k % 13] / 4)) begin fails++;
        $display("FAIL pass_bird k=%0d: got state %0d row %0d want state 1 row %0d",
                 k, state, bird_row, cyc_y[k % 13] / 4); end
      checks++; if (pipe_x !== ((k < 80) ? 8'(39 - k / 2) : 8'd39)) begin fails++;
        $display("FAIL pass_pipe k=%0d: got %0d want %0d", k, pipe_x,
                 (k < 80) ? 39 - k / 2 : 39); end
      checks++; if (score !== ((k >= 64) ? 16'd1 : 16'd0)) begin fails++;
        $display("FAIL pass_score k=%0d: got %0d want %0d", k, score, (k >= 64) ? 1 : 0); end
    end
    exp_gap_wrap = 16'd1 + (lfsr_after(80) % 16'd13);
    checks++; if (gap_top < 8'd1 || gap_top > 8'd13) begin fails++;
      $display("FAIL pass_gap_range: got %0d want 1..13", gap_top); end
    checks++; if (gap_top !== exp_gap_wrap[7:0]) begin fails++;
      $display("FAIL pass_gap_value: got %0d want %0d", gap_top, exp_gap_wrap); end
  endtask

  task automatic test_floor_restart();
    int n;
    n = 0;
    while (state !== 2'd2 && n < 40) begin
      frame(1'b0);
      n++;
    end
    checks++; if (n !== 16) begin fails++;
      $display("FAIL floor_frames: got %0d want 16", n); end
    checks++; if (bird_row !== 8'd19 || pipe_x !== 8'd31 || score !== 16'd1) begin fails++;
      $display("FAIL floor_dead: got row %0d pipe %0d score %0d want 19/31/1",
               bird_row, pipe_x, score); end
    for (int i = 0; i < 10; i++) frame(1'b0);
    checks++; if (state !== 2'd2 || pipe_x !== 8'd31 || bird_row !== 8'd19 ||
                  gap_top !== exp_gap_wrap[7:0] || score !== 16'd1) begin fails++;
      $display("FAIL dead_frozen: got %0d/%0d/%0d/%0d/%0d want 2/31/19/%0d/1",
               state, pipe_x, bird_row, gap_top, score, exp_gap_wrap); end
    frame(1'b1);
    checks++; if (state !== 2'd2) begin fails++;
      $display("FAIL restart_early10: got %0d want 2", state); end
    for (int i = 0; i < 18; i++) frame(1'b0);
    frame(1'b1);
    checks++; if (state !== 2'd2) begin fails++;
      $display("FAIL restart_early29: got %0d want 2", state); end
    frame(1'b0);
    checks++; if (state !== 2'd2) begin fails++;
      $display("FAIL restart_no_flap: got %0d want 2", state); end
    frame(1'b1);
    checks++; if (state !== 2'd0 || pipe_x !== 8'd39 || bird_row !== 8'd10 ||
                  gap_top !== 8'd7 || score !== 16'd1) begin fails++;
      $display("FAIL restart_ready: got %0d/%0d/%0d/%0d/%0d want 0/39/10/7/1",
               state, pipe_x, bird_row, gap_top, score); end
    frame(1'b0);
    frame(1'b0);
    checks++; if (state !== 2'd0 || bird_row !== 8'd10 || score !== 16'd1) begin fails++;
      $display("FAIL ready_hold: got %0d/%0d/%0d want 0/10/1", state, bird_row, score); end
    frame(1'b1);
    checks++; if (state !== 2'd1 || score !== 16'd0 || bird_row !== 8'd8) begin fails++;
      $display("FAIL replay_entry: got %0d/%0d/%0d want 1/0/8", state, score, bird_row); end
    // Held key must not act again: y 29, 25, 22.
    for (int i = 0; i < 3; i++) begin
      frame(1'b1);
      checks++; if (bird_row !== 8'(fall_y[i] / 4)) begin fails++;
        $display("FAIL held_flap i=%0d: got %0d want %0d", i, bird_row, fall_y[i] / 4); end
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    frame(1'b1);
    for (int k = 1; k <= 66; k++) frame(k % 13 == 0);
    checks++; if (state !== 2'd1 || score !== 16'd1) begin fails++;
      $display("FAIL midplay_pre: got state %0d score %0d want 1/1", state, score); end
    rst = 1'b1;
    frame(1'b0);
    rst = 1'b0;
    checks++; if (state !== 2'd0 || bird_row !== 8'd10 || pipe_x !== 8'd39 ||
                  gap_top !== 8'd7 || score !== 16'd0) begin fails++;
      $display("FAIL midplay_reset: got %0d/%0d/%0d/%0d/%0d want 0/10/39/7/0",
               state, bird_row, pipe_x, gap_top, score); end
    frame(1'b1);
    frame(1'b0);
    checks++; if (bird_row !== 8'd7 || pipe_x !== 8'd39) begin fails++;
      $display("FAIL midplay_resume1: got row %0d pipe %0d want 7/39", bird_row, pipe_x); end
    frame(1'b0);
    checks++; if (bird_row !== 8'd6 || pipe_x !== 8'd38) begin fails++;
      $display("FAIL midplay_resume2: got row %0d pipe %0d want 6/38", bird_row, pipe_x); end
  endtask

  task automatic test_ceiling();
    int rows_flap[20] = '{7, 5, 4, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int rows_fall[8]  = '{0, 0, 1, 2, 3, 5, 7, 9};
    do_reset();
    frame(1'b1);
    for (int i = 1; i <= 20; i++) begin
      frame(i % 2 == 0);
      checks++; if (state !== 2'd1 || bird_row !== 8'(rows_flap[i-1])) begin fails++;
        $display("FAIL ceiling i=%0d: got state %0d row %0d want 1/%0d",
                 i, state, bird_row, rows_flap[i-1]); end
    end
    // Velocity was zeroed at the clamp, so the fall restarts from rest.
    for (int i = 0; i < 8; i++) begin
      frame(1'b0);
      checks++; if (state !== 2'd1 || bird_row !== 8'(rows_fall[i])) begin fails++;
        $display("FAIL ceiling_fall i=%0d: got state %0d row %0d want 1/%0d",
                 i, state, bird_row, rows_fall[i]); end
    end
  endtask

  task automatic test_pipe_hit();
    do_reset();
    frame(1'b1);
    for (int k = 1; k <= 61; k++) frame(k % 2 == 0);
    checks++; if (state !== 2'd1 || pipe_x !== 8'd9 || bird_row !== 8'd0) begin fails++;
      $display("FAIL hit_pre: got %0d/%0d/%0d want 1/9/0", state, pipe_x, bird_row); end
    frame(1'b1);
    checks++; if (state !== 2'd2 || pipe_x !== 8'd8 || score !== 16'd0) begin fails++;
      $display("FAIL hit_dead: got %0d/%0d/%0d want 2/8/0", state, pipe_x, score); end
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);
    checks++; if (state !== 2'd2 || pipe_x !== 8'd8 || bird_row !== 8'd0) begin fails++;
      $display("FAIL hit_frozen: got %0d/%0d/%0d want 2/8/0", state, pipe_x, bird_row); end
  endtask

  initial begin
    test_reset();
    test_ideal_fall();
    test_reset_from_dead();
    test_pipe_pass();
    test_floor_restart();
    test_reset_mid_play();
    test_ceiling();
    test_pipe_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/flappy_physics.md
# flappy_physics

Per-frame game-state engine for the terminal Flappy Bird. Each rising edge of the frame clock from the engine block is one game frame. The block consumes the player's flap input and advances bird physics, pipe scrolling, collision detection and score. Its registered outputs feed the view stage, which renders them every frame.

## Interface
- `WIDTH`, default 40: playfield columns.
- `HEIGHT`, default 20: playfield rows.
- `BIRD_X`, default 8: fixed bird column; must be at least 1.
- `GAP`, default 6: pipe gap height in rows.
- `GRAVITY`, default 1: velocity increment per frame, in quarter-rows per frame.
- `FLAP_VEL`, default 6: upward speed set by a flap, in quarter-rows per frame.
- `MAX_FALL`, default 8: downward velocity cap.
- `SCROLL_DIV`, default 2: frames per one-column pipe shift.
- `DEAD_HOLD`, default 30: minimum frames spent in DEAD before a restart is accepted.

Ports (direction, width, meaning):
- `clk`, in, 1: frame clock, one edge per frame.
- `rst`, in, 1: reset, synchronous and active-high.
- `flap`, in, 1: player key level, sampled each frame; only its rising edge acts.
- `state`, out, 2: 0 = READY, 1 = PLAY, 2 = DEAD.
- `bird_row`, out, 8: bird row, equal to y >> 2.
- `pipe_x`, out, 8: pipe column.
- `gap_top`, out, 8: first open row of the gap.
- `score`, out, 16: pipes passed.

## Operation
- **Internal state:**
  - y: 8-bit unsigned, in quarter-rows.
  - vel: 8-bit signed; positive means down.
  - scroll counter; dead counter.
  - flap_q, the previous flap sample.
  - 16-bit Fibonacci LFSR: taps 16, 14, 13, 11; seed 16'hACE1.
- **Flap edge:** fe = flap & ~flap_q.
- **LFSR:** steps every frame in every state except reset.
- **READY:**
  - Hold y = HEIGHT*2 (row 10), vel = 0, pipe_x = WIDTH-1, gap_top = (HEIGHT-GAP)/2.
  - fe causes the following in one frame: score := 0, vel := -FLAP_VEL, y := HEIGHT*2 - FLAP_VEL, state := PLAY.
- **PLAY, vel update** (per frame):
  - vel_n = fe ? -FLAP_VEL : min(vel + GRAVITY, MAX_FALL).
- **PLAY, position update:**
  - y_n = y + vel_n, computed 9-bit signed.
  - If y_n < 0: y := 0 and vel := 0.
  - If y_n >= HEIGHT*4: y := HEIGHT*4 - 1 and state := DEAD.
- **PLAY, pipe scroll:**
  - Each frame the scroll counter counts 0 .. SCROLL_DIV-1.
  - At terminal count, pipe_x decrements.
  - At pipe_x == 0 it wraps to WIDTH-1 and loads gap_top := 1 + (lfsr mod (HEIGHT-GAP-1)).
- **PLAY, score:** +1 on the frame pipe_x moves from BIRD_X to BIRD_X-1. Saturates at 16'hFFFF.
- **PLAY, collision:**
  - Evaluated on post-update values: pipe_x_n == BIRD_X and (row_n < gap_top_n or row_n >= gap_top_n + GAP).
  - On collision: state := DEAD. All registers still take their updated values that frame.
- **DEAD:**
  - y, vel, pipe_x, gap_top and score freeze.
  - The dead counter counts up to DEAD_HOLD.
  - fe after the count completes goes to READY, with the READY values loaded that frame. Score is retained until the next PLAY entry.
- **Simultaneous events:** bottom hit and pipe hit in the same frame give a single DEAD entry. Score never increments on a collision frame, because the two require different pipe_x values.

## Timing
- All outputs are registered and change only at posedge clk.
- **Reset values:** state = 0, bird_row = HEIGHT/2, pipe_x = WIDTH-1, gap_top = (HEIGHT-GAP)/2, score = 0. Internally: vel = 0, flap_q = 0, scroll counter = 0, dead counter = 0, lfsr = 16'hACE1.
- **Reset mid-PLAY or mid-DEAD:** on the next edge, return to the reset values above.
- **Latency:** flap is sampled at edge N; its effect appears on the outputs after edge N. One frame of latency, with no combinational input-to-output path.
- **Held flap:** yields exactly one flap. It must be released and pressed again to produce another.
- **Arithmetic:** vel is clamped before the add. Arithmetic on y is 9-bit so overflow cannot wrap.

## Test plan
- **Ideal fall:** rst for 2 frames, then flap high for one frame.
  - Expected: state = 1 and bird_row = 8 (y = 34).
  - Without further flaps, y follows 29, 25, 22, 20, 19, 19, 20, 22, 25, 29, 34, 40, 47, 55, 63, 71, 79.
  - The next frame: state = 2, bird_row = 19, score = 0.
- **Ceiling:** start, then pulse flap (high, low alternating) every other frame for 20 frames. Expected: y never goes below 0, bird_row = 0 is reached, vel = 0 on the clamp frame, no DEAD.
- **Pipe pass:** force the gap to cover the bird by holding it near row 10 with a flap cadence. Expected: score = 1 on the frame pipe_x reads 7; pipe_x wraps to 39 after 0; new gap_top is in 1..13.
- **Pipe hit:** with no flaps, let the bird rest low (dies by floor first). Then place the bird at row 0 with pipe_x = 9. Expected: DEAD on the frame pipe_x becomes 8, score unchanged.
- **Restart hold:** in DEAD, flap at dead count 10. Expected: ignored. Flap again after 30 frames: state = 0, pipe_x = 39, bird_row = 10 next frame; score kept until the next flap zeroes it.
- **Reset mid-play:** assert rst for one frame at score = 1. Expected: all outputs at reset values on the next edge.
